pipeexe_alu: RTL and testbench
==============================

# pipeexe_alu

Execute-stage ALU for the five-stage pipeline. It consumes the 5-bit `aluc` code and the forwarded operands produced by the ID-stage control/forwarding logic, and returns the EXE result. For the MUL code it runs an iterative 32-cycle shift-add multiplier and holds the front of the pipeline with `stall` until the product is ready. It sits between the ID/EXE pipeline register and the EXE/MEM pipeline register, and `r` also feeds the EXE forwarding path.

## Interface
- No parameters. The datapath is fixed at 32 bits.
- `clock` in 1: pipeline clock. All state changes on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `e_valid` in 1: a live (non-bubble) instruction occupies EXE this cycle.
- `flush` in 1: cancels the instruction in EXE (branch taken in EXE/MEM).
- `aluc` in 5: ALU operation code from the ID stage, registered through ID/EXE.
- `a` in 32: operand A after forwarding mux. For shifts it carries `sa` in bits [4:0].
- `b` in 32: operand B after forwarding or immediate mux.
- `r` out 32: EXE result, combinational except during a multiply.
- `stall` out 1: freezes PC, IF/ID and ID/EXE. When high, EXE/MEM must load a bubble.
- `mul_busy` out 1: the multiplier FSM is not IDLE. Used for debug and verification.

## Operation
- aluc decode. Any other code gives r = 0.
  - 00000 ADD: a+b, wrapping, no overflow flag.
  - 01000 SUB: a−b.
  - 00010 AND.
  - 01010 OR.
  - 01011 XOR. Also used by beq/bne.
  - 00100 LUI: {b[15:0], 16'h0}.
  - 00101 SLL: b << a[4:0].
  - 01101 SRL: logical b >> a[4:0].
  - 11101 SRA: arithmetic b >>> a[4:0].
  - 00001 MUL: low 32 bits of a×b. Signedness is irrelevant for the low word.
- Non-MUL codes are purely combinational. stall = 0 and the result is valid in the same cycle.
- Multiplier FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY when e_valid & aluc==00001 & ~flush.
    - Latch multiplicand = a and multiplier = b.
    - Clear accumulator and 6-bit counter.
  - BUSY: each edge does the following.
    - If multiplier[0] is 1, add multiplicand to accumulator.
    - Shift multiplicand left 1 and multiplier right 1.
    - Increment the counter.
    - Go to DONE on the edge where the counter goes 31→32.
  - DONE → IDLE unconditionally on the next edge.
  - flush in BUSY or DONE → IDLE on the next edge. The accumulator is discarded.
- stall equations:
  - stall = (state==IDLE & e_valid & aluc==00001 & ~flush) | (state==BUSY & ~flush).
  - stall = 0 in DONE.
  - stall = 0 while resetn is low.
- r during multiply:
  - r = accumulator in DONE.
  - r = 0 in IDLE or BUSY while aluc==00001.
- DONE does not re-trigger on the same instruction, because the pipeline advances at the DONE edge. Back-to-back MULs therefore each take the full sequence.
- e_valid is ignored in BUSY and DONE. ID/EXE is frozen by stall, so the inputs stay stable.

## Timing
- Reset values:
  - state = IDLE, counter = 0, accumulator = 0, multiplicand/multiplier = 0.
  - stall = 0, mul_busy = 0, r = 0.
- ALU ops have 0 cycles of latency (combinational through EXE).
- MUL latency, with the MUL present in cycle 0:
  - stall is high in cycles 0–32 (33 cycles).
  - Cycle 33 is DONE: stall = 0 and r = product. EXE/MEM captures it at the end of cycle 33.
  - Total EXE occupancy is 34 cycles.
- mul_busy is high in cycles 1–33.
- Boundary cases:
  - flush in cycle 0 (IDLE): the FSM does not start and stall = 0.
  - flush in a BUSY cycle k: stall drops in cycle k, and the FSM is IDLE in cycle k+1.
  - flush in DONE: r is still driven, but the downstream discards it. The FSM goes IDLE.
  - resetn low mid-BUSY: immediate asynchronous return to IDLE with all state cleared. stall drops without waiting for a clock edge.
  - Counter width is 6 bits. Reaching 32 is the terminal condition, and the counter never wraps.

## Test plan
- ALU sweep, each with e_valid=1:
  - a=32'h0000_0004, b=32'h8000_00F0.
  - ADD → 32'h8000_00F4.
  - SUB (a−b) → 32'h7FFF_FF14.
  - SLL → 32'h0000_0F00.
  - SRL → 32'h0800_000F.
  - SRA → 32'hF800_000F.
  - LUI → 32'h00F0_0000.
  - stall stays 0 throughout.
- MUL a=7, b=6:
  - stall is high for exactly 33 cycles.
  - In cycle 33: r=42, stall=0, mul_busy=1.
  - mul_busy=0 in cycle 34.
- MUL a=32'hFFFF_FFFF, b=32'hFFFF_FFFF → r=32'h0000_0001 in DONE. Wrap/truncation check.
- Back-to-back MULs (3×5, then 9×9):
  - Results 15 and 81.
  - Each is preceded by its own 33-cycle stall window. No stall-free gap except the DONE cycles.
- flush asserted in BUSY cycle 10 of a MUL:
  - stall is 0 in cycle 10.
  - The FSM is IDLE in cycle 11.
  - A following ADD 1+1 gives r=2 with no stall.
- resetn pulsed low in BUSY cycle 5:
  - stall and mul_busy fall asynchronously.
  - After release, the FSM is in IDLE and r=0 with aluc=00001 and e_valid=0.

Source files
------------

// File: rtl/pipeexe_alu.sv
`default_nettype none
// ============================================================================
// Module      : pipeexe_alu
// Description : Execute-stage ALU for a five-stage pipeline. Add, subtract,
//               logic, LUI and shift operations are combinational. MUL runs
//               an iterative 32-step shift-add multiplier that holds the
//               front of the pipeline with stall until the product is ready.
//
// Ports
//   clock    in   1  pipeline clock, rising edge
//   resetn   in   1  asynchronous active-low reset
//   e_valid  in   1  live instruction in EXE this cycle
//   flush    in   1  cancel the instruction in EXE
//   aluc     in   5  ALU operation code
//   a        in  32  operand A (shift amount in [4:0] for shifts)
//   b        in  32  operand B
//   r        out 32  EXE result
//   stall    out  1  freeze PC, IF/ID, ID/EXE; bubble into EXE/MEM
//   mul_busy out  1  multiplier FSM not idle
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipeexe_alu (
    input  logic        clock,
    input  logic        resetn,
    input  logic        e_valid,
    input  logic        flush,
    input  logic [4:0]  aluc,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output logic        stall,
    output logic        mul_busy
);

    // Operation codes
    localparam logic [4:0] c_OP_ADD = 5'b00000;
    localparam logic [4:0] c_OP_SUB = 5'b01000;
    localparam logic [4:0] c_OP_AND = 5'b00010;
    localparam logic [4:0] c_OP_OR  = 5'b01010;
    localparam logic [4:0] c_OP_XOR = 5'b01011;
    localparam logic [4:0] c_OP_LUI = 5'b00100;
    localparam logic [4:0] c_OP_SLL = 5'b00101;
    localparam logic [4:0] c_OP_SRL = 5'b01101;
    localparam logic [4:0] c_OP_SRA = 5'b11101;
    localparam logic [4:0] c_OP_MUL = 5'b00001;

    // Multiplier FSM states
    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_BUSY = 2'b01;
    localparam logic [1:0] c_ST_DONE = 2'b10;

    localparam logic [5:0] c_CNT_LAST = 6'd31;

    logic [1:0]  r_state;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [5:0]  r_cnt;

    logic        w_is_mul;
    logic        w_mul_start;
    logic [31:0] w_r;

    assign w_is_mul    = (aluc == c_OP_MUL);
    assign w_mul_start = (r_state == c_ST_IDLE) & e_valid & w_is_mul & ~flush;

    // resetn gates stall directly so it falls the moment reset is applied,
    // even if a MUL is still presented on the inputs.
    assign stall    = resetn & (w_mul_start | ((r_state == c_ST_BUSY) & ~flush));
    assign mul_busy = (r_state != c_ST_IDLE);

    // ------------------------------------------------------------------------
    // Multiplier FSM. The counter stops at 32 because DONE always returns
    // to IDLE, so it never wraps.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= c_ST_IDLE;
            r_mcand  <= 32'h0;
            r_mplier <= 32'h0;
            r_acc    <= 32'h0;
            r_cnt    <= 6'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_mul_start) begin
                        r_state  <= c_ST_BUSY;
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= 32'h0;
                        r_cnt    <= 6'd0;
                    end
                end
                c_ST_BUSY: begin
                    if (flush) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= {r_mcand[30:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[31:1]};
                        r_cnt    <= r_cnt + 6'd1;
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Result mux. MUL shows the accumulator only once it is complete.
    // ------------------------------------------------------------------------
    always_comb begin
        w_r = 32'h0;
        case (aluc)
            c_OP_ADD: w_r = a + b;
            c_OP_SUB: w_r = a - b;
            c_OP_AND: w_r = a & b;
            c_OP_OR:  w_r = a | b;
            c_OP_XOR: w_r = a ^ b;
            c_OP_LUI: w_r = {b[15:0], 16'h0};
            c_OP_SLL: w_r = b << a[4:0];
            c_OP_SRL: w_r = b >> a[4:0];
            c_OP_SRA: w_r = $unsigned($signed(b) >>> a[4:0]);
            c_OP_MUL: w_r = (r_state == c_ST_DONE) ? r_acc : 32'h0;
            default:  w_r = 32'h0;
        endcase
    end

    assign r = w_r;

endmodule
`default_nettype wire

// File: tb/tb_pipeexe_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeexe_alu
// Description : Scoreboard bench for pipeexe_alu. Stimulus pushes expected
//               results; a negedge monitor pops and compares whenever the
//               DUT presents a result (live, unflushed, not stalled).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeexe_alu;

    localparam logic [4:0] c_ADD = 5'b00000;
    localparam logic [4:0] c_SUB = 5'b01000;
    localparam logic [4:0] c_AND = 5'b00010;
    localparam logic [4:0] c_OR  = 5'b01010;
    localparam logic [4:0] c_XOR = 5'b01011;
    localparam logic [4:0] c_LUI = 5'b00100;
    localparam logic [4:0] c_SLL = 5'b00101;
    localparam logic [4:0] c_SRL = 5'b01101;
    localparam logic [4:0] c_SRA = 5'b11101;
    localparam logic [4:0] c_MUL = 5'b00001;

    logic        clock = 1'b0;
    logic        resetn;
    logic        e_valid;
    logic        flush;
    logic [4:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        stall;
    logic        mul_busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    pipeexe_alu dut (
        .clock    (clock),
        .resetn   (resetn),
        .e_valid  (e_valid),
        .flush    (flush),
        .aluc     (aluc),
        .a        (a),
        .b        (b),
        .r        (r),
        .stall    (stall),
        .mul_busy (mul_busy)
    );

    always #5 clock = ~clock;

    // Reference model: the instruction-set meaning of each code.
    function automatic logic [31:0] ref_alu(input logic [4:0] c,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        logic [63:0] p;
        logic signed [31:0] ys;
        int sh;
        sh = int'(x[4:0]);
        ys = y;
        p  = {32'h0, x} * {32'h0, y};
        case (c)
            c_ADD:   return x + y;
            c_SUB:   return x - y;
            c_AND:   return x & y;
            c_OR:    return x | y;
            c_XOR:   return x ^ y;
            c_LUI:   return {y[15:0], 16'h0};
            c_SLL:   return y << sh;
            c_SRL:   return y >> sh;
            c_SRA:   return ys >>> sh;
            c_MUL:   return p[31:0];
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (resetn === 1'b1 && e_valid === 1'b1 && flush === 1'b0 && stall === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got result %h with no expected entry", r);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (r !== e) begin
                    failures++;
                    $display("FAIL sb_result: got %h expected %h (aluc=%b)", r, e, aluc);
                end
            end
        end
    end

    // Single-cycle ALU op: drives, records expectation, checks no stall.
    task automatic alu_op(input logic [4:0] c, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] expv);
        @(posedge clock); #1;
        e_valid = 1'b1; flush = 1'b0; aluc = c; a = x; b = y;
        exp_q.push_back(expv);
        @(negedge clock);
        chk("alu_stall", {31'h0, stall}, 32'h0);
    endtask

    // Full MUL: counts stall cycles, checks the DONE cycle's flags.
    task automatic mul_op(input logic [31:0] x, input logic [31:0] y);
        int  n;
        bit  done;
        @(posedge clock); #1;
        e_valid = 1'b1; flush = 1'b0; aluc = c_MUL; a = x; b = y;
        exp_q.push_back(ref_alu(c_MUL, x, y));
        n = 0; done = 0;
        while (!done && n < 100) begin
            @(negedge clock);
            if (stall) n++;
            else done = 1;
        end
        chk("mul_stall_cycles", n, 33);
        chk("mul_busy_done", {31'h0, mul_busy}, 32'h1);
    endtask

    task automatic idle_cycle();
        @(posedge clock); #1;
        e_valid = 1'b0; flush = 1'b0; aluc = c_ADD; a = 32'h0; b = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  rc;
        logic [31:0] ra, rb;

        resetn = 1'b0; e_valid = 1'b0; flush = 1'b0;
        aluc = c_ADD; a = 32'h0; b = 32'h0;

        // Reset state
        @(negedge clock);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_busy",  {31'h0, mul_busy}, 32'h0);
        chk("rst_r",     r, 32'h0);
        @(posedge clock); #1;
        resetn = 1'b1;
        idle_cycle();

        // Directed ALU sweep
        alu_op(c_ADD, 32'h0000_0004, 32'h8000_00F0, 32'h8000_00F4);
        alu_op(c_SUB, 32'h0000_0004, 32'h8000_00F0, 32'h7FFF_FF14);
        alu_op(c_SLL, 32'h0000_0004, 32'h8000_00F0, 32'h0000_0F00);
        alu_op(c_SRL, 32'h0000_0004, 32'h8000_00F0, 32'h0800_000F);
        alu_op(c_SRA, 32'h0000_0004, 32'h8000_00F0, 32'hF800_000F);
        alu_op(c_LUI, 32'h0000_0004, 32'h8000_00F0, 32'h00F0_0000);
        alu_op(5'b11111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);

        // MUL 7x6
        mul_op(32'd7, 32'd6);
        idle_cycle();
        @(negedge clock);
        chk("mul_busy_after_done", {31'h0, mul_busy}, 32'h0);

        // Wrap/truncation
        mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Back-to-back
        mul_op(32'd3, 32'd5);
        mul_op(32'd9, 32'd9);
        idle_cycle();

        // Flush in cycle 0: FSM must not start
        @(posedge clock); #1;
        e_valid = 1'b1; flush = 1'b1; aluc = c_MUL; a = 32'd3; b = 32'd3;
        @(negedge clock);
        chk("flush0_stall", {31'h0, stall}, 32'h0);
        idle_cycle();
        @(negedge clock);
        chk("flush0_busy", {31'h0, mul_busy}, 32'h0);

        // Flush in BUSY cycle 10
        @(posedge clock); #1;
        e_valid = 1'b1; flush = 1'b0; aluc = c_MUL; a = 32'd11; b = 32'd13;
        for (int k = 1; k <= 10; k++) @(posedge clock);
        #1 flush = 1'b1;
        @(negedge clock);
        chk("flush10_stall", {31'h0, stall}, 32'h0);
        chk("flush10_busy",  {31'h0, mul_busy}, 32'h1);
        alu_op(c_ADD, 32'd1, 32'd1, 32'd2);
        chk("flush11_idle", {31'h0, mul_busy}, 32'h0);

        // Reset pulse in BUSY cycle 5
        @(posedge clock); #1;
        e_valid = 1'b1; flush = 1'b0; aluc = c_MUL; a = 32'd21; b = 32'd2;
        for (int k = 1; k <= 5; k++) @(posedge clock);
        @(negedge clock);
        chk("pre_rst_stall", {31'h0, stall}, 32'h1);
        #1 resetn = 1'b0;
        #1;
        chk("async_rst_stall", {31'h0, stall}, 32'h0);
        chk("async_rst_busy",  {31'h0, mul_busy}, 32'h0);
        e_valid = 1'b0;
        #1 resetn = 1'b1;
        @(negedge clock);
        chk("post_rst_busy", {31'h0, mul_busy}, 32'h0);
        chk("post_rst_r",    r, 32'h0);
        chk("post_rst_stall", {31'h0, stall}, 32'h0);

        // Randomized ALU ops (non-MUL codes, including undefined ones)
        for (int i = 0; i < 40; i++) begin
            rc = 5'($urandom_range(0, 31));
            if (rc == c_MUL) rc = c_XOR;
            ra = $urandom;
            rb = $urandom;
            alu_op(rc, ra, rb, ref_alu(rc, ra, rb));
        end

        // Randomized MULs
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            mul_op(ra, rb);
        end
        idle_cycle();
        @(negedge clock);

        chk("sb_drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
